rv_prefetch_fetch_stage: RTL and testbench

//  Parametrised successor of the single-request fetch stage for the 5-stage RV32IM pipeline.

---
 rtl/rv_prefetch_fetch_stage.sv | 156 +++++++++++++++
 tb/tb_rv_prefetch_fetch_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_prefetch_fetch_stage.sv
// -----------------------------------------------------------------------------
// rv_prefetch_fetch_stage
//
// Instruction fetch stage with an in-order prefetch buffer for the 5-stage
// RV32IM pipeline. Up to MAX_OUTSTANDING requests may be in flight. Returned
// words are queued with their PCs in a DEPTH-entry FIFO that decode consumes
// from the head, so memory latency is hidden behind decode stalls.
//
// Ports
//   clk_i, arstn_i    clock, asynchronous active-low reset
//   boot_addr_i       first fetch address after reset (low two bits ignored)
//   cu_kill_f_i       mask f_valid_o this cycle (no pop, FIFO retained)
//   cu_stall_f_i      decode not accepting; hold the FIFO head
//   cu_force_f_i      redirect: flush FIFO, drop in-flight responses,
//                     restart fetching at cu_force_pc_i
//   cu_force_pc_i     redirect target (low two bits ignored)
//   f_stall_req_o     FIFO empty, no instruction available
//   instr_req_o       request; memory accepts every asserted cycle
//   instr_addr_o      request address, word aligned
//   instr_rvalid_i    in-order response valid (latency >= 1, never unsolicited)
//   instr_rdata_i     response word
//   f_instr_o         FIFO head instruction
//   f_current_pc_o    PC of the head instruction
//   f_next_pc_o       f_current_pc_o + 4
//   f_valid_o         head valid to decode
//
// Handshake: the memory side has no ready; a request is taken in every cycle
// instr_req_o is high. Towards decode, an instruction is consumed in a cycle
// where f_valid_o is high and cu_stall_f_i is low.
// -----------------------------------------------------------------------------
module rv_prefetch_fetch_stage #(
  parameter int XLEN            = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic [XLEN-1:0] boot_addr_i,
  input  logic            cu_kill_f_i,
  input  logic            cu_stall_f_i,
  input  logic            cu_force_f_i,
  input  logic [XLEN-1:0] cu_force_pc_i,
  output logic            f_stall_req_o,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  output logic [XLEN-1:0] f_instr_o,
  output logic [XLEN-1:0] f_current_pc_o,
  output logic [XLEN-1:0] f_next_pc_o,
  output logic            f_valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;                      // FIFO occupancy 0..DEPTH
  localparam int CW = $clog2(MAX_OUTSTANDING + 1); // in-flight counters
  localparam int SW = NW + 1;                      // occupancy + in-flight sum

  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [NW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic            booted;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] resp_pc;

  logic            empty;
  logic            issue;
  logic            push;
  logic            pop;
  logic [SW-1:0]   credit_used;
  logic [XLEN-1:0] boot_pc;
  logic [XLEN-1:0] force_pc;

  assign boot_pc  = boot_addr_i   & ~XLEN'(3);
  assign force_pc = cu_force_pc_i & ~XLEN'(3);

  assign empty = (count == '0);

  // Every in-flight request reserves a FIFO slot, so a response always has
  // room even if decode never pops.
  assign credit_used = SW'(count) + SW'(outstanding);
  assign issue = !cu_force_f_i
              && (outstanding < CW'(MAX_OUTSTANDING))
              && (credit_used < SW'(DEPTH));

  assign instr_req_o  = issue;
  assign instr_addr_o = booted ? req_pc : boot_pc;

  assign f_valid_o      = !empty && !cu_kill_f_i && !cu_force_f_i;
  assign f_stall_req_o  = empty;
  assign f_instr_o      = data_q[rd_ptr];
  assign f_current_pc_o = pc_q[rd_ptr];
  assign f_next_pc_o    = pc_q[rd_ptr] + XLEN'(4);

  assign pop  = f_valid_o && !cu_stall_f_i;
  // Responses in the redirect cycle, or while stale ones remain, are dropped.
  assign push = instr_rvalid_i && !cu_force_f_i && (discard == '0);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      outstanding <= '0;
      discard     <= '0;
      booted      <= 1'b0;
      req_pc      <= '0;
      resp_pc     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(instr_rvalid_i);
      if (cu_force_f_i) begin
        // Every request still in flight, stale or not, becomes stale; the
        // response landing this cycle is already being dropped.
        discard <= outstanding - CW'(instr_rvalid_i);
        req_pc  <= force_pc;
        resp_pc <= force_pc;
        booted  <= 1'b1;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
      end else begin
        if (instr_rvalid_i && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        if (issue) begin
          req_pc <= instr_addr_o + XLEN'(4);
          booted <= 1'b1;
          // First request after reset: responses start at the boot PC.
          // Nothing can be in flight yet, so no push competes for resp_pc.
          if (!booted) begin
            resp_pc <= boot_pc;
          end
        end
        if (push) begin
          data_q[wr_ptr] <= instr_rdata_i;
          pc_q[wr_ptr]   <= resp_pc;
          wr_ptr         <= wr_ptr + AW'(1);
          resp_pc        <= resp_pc + XLEN'(4);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + NW'(push) - NW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_rv_prefetch_fetch_stage.sv
// -----------------------------------------------------------------------------
// Bench for rv_prefetch_fetch_stage. A memory model returns words in order
// with a per-phase latency range. The reference tags each request with a
// redirect epoch: a response whose epoch is current is an instruction decode
// must see, anything else is stale. Expected FIFO contents live in exp_q as
// {data, pc}; expected request addresses follow the sequential PC stream.
// -----------------------------------------------------------------------------
module tb_rv_prefetch_fetch_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
    int              epoch;
  } mreq_t;

  logic            clk = 1'b0;
  logic            arstn;
  logic [XLEN-1:0] boot_addr;
  logic            cu_kill;
  logic            cu_stall;
  logic            cu_force;
  logic [XLEN-1:0] cu_force_pc;
  logic            f_stall_req;
  logic            instr_rvalid;
  logic [XLEN-1:0] instr_rdata;
  logic            instr_req;
  logic [XLEN-1:0] instr_addr;
  logic [XLEN-1:0] f_instr;
  logic [XLEN-1:0] f_current_pc;
  logic [XLEN-1:0] f_next_pc;
  logic            f_valid;

  rv_prefetch_fetch_stage #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i          (clk),
    .arstn_i        (arstn),
    .boot_addr_i    (boot_addr),
    .cu_kill_f_i    (cu_kill),
    .cu_stall_f_i   (cu_stall),
    .cu_force_f_i   (cu_force),
    .cu_force_pc_i  (cu_force_pc),
    .f_stall_req_o  (f_stall_req),
    .instr_rvalid_i (instr_rvalid),
    .instr_rdata_i  (instr_rdata),
    .instr_req_o    (instr_req),
    .instr_addr_o   (instr_addr),
    .f_instr_o      (f_instr),
    .f_current_pc_o (f_current_pc),
    .f_next_pc_o    (f_next_pc),
    .f_valid_o      (f_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference state ----------------
  int              n_vec    = 0;
  int              n_err    = 0;
  int              cyc      = 0;
  int              epoch    = 0;
  int              last_due = 0;
  logic [XLEN-1:0] exp_addr;
  mreq_t           mem_q[$];
  logic [2*XLEN-1:0] exp_q[$];   // {data, pc}

  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_val(input string tag, input logic [XLEN-1:0] got,
                           input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reset driver ----------------
  task automatic do_reset(input logic [XLEN-1:0] boot);
    @(negedge clk);
    arstn        = 1'b0;
    boot_addr    = boot;
    cu_kill      = 1'b0;
    cu_stall     = 1'b0;
    cu_force     = 1'b0;
    cu_force_pc  = '0;
    instr_rvalid = 1'b0;
    instr_rdata  = '0;
    repeat (2) begin
      @(negedge clk);
      #1;
      check_val("rst_f_valid", {31'b0, f_valid}, 32'd0);
      check_val("rst_f_stall_req", {31'b0, f_stall_req}, 32'd1);
      check_val("rst_f_instr", f_instr, 32'd0);
      check_val("rst_f_pc", f_current_pc, 32'd0);
    end
    mem_q.delete();
    exp_q.delete();
    epoch++;
    last_due = cyc;
    exp_addr = boot & ~32'd3;
    @(posedge clk);
    #1;
    arstn = 1'b1;
  endtask

  // ---------------- one cycle: drive, check, advance model ----------------
  task automatic step(input int lat_lo, input int lat_hi, input int p_stall,
                      input int p_kill, input int p_force,
                      input bit fixed_pc, input logic [XLEN-1:0] fpc);
    bit                resp;
    mreq_t             r;
    mreq_t             nr;
    logic              exp_valid;
    logic              exp_req;
    logic [2*XLEN-1:0] head;
    int                due;

    @(negedge clk);
    cyc++;
    resp         = (mem_q.size() > 0) && (mem_q[0].due == cyc);
    instr_rvalid = resp;
    instr_rdata  = resp ? mem_word(mem_q[0].addr) : $urandom();
    cu_stall     = ($urandom_range(99) < p_stall);
    cu_kill      = ($urandom_range(99) < p_kill);
    cu_force     = ($urandom_range(99) < p_force);
    cu_force_pc  = fixed_pc ? fpc : $urandom();
    #1;

    exp_valid = (exp_q.size() > 0) && !cu_kill && !cu_force;
    exp_req   = !cu_force && (mem_q.size() < MAXO)
             && (exp_q.size() + mem_q.size() < DEPTH);

    check_val("f_valid", {31'b0, f_valid}, {31'b0, exp_valid});
    check_val("f_stall_req", {31'b0, f_stall_req}, {31'b0, exp_q.size() == 0});
    check_val("instr_req", {31'b0, instr_req}, {31'b0, exp_req});
    if (exp_valid) begin
      head = exp_q[0];
      check_val("f_current_pc", f_current_pc, head[XLEN-1:0]);
      check_val("f_instr", f_instr, head[2*XLEN-1:XLEN]);
      check_val("f_next_pc", f_next_pc, head[XLEN-1:0] + 32'd4);
    end
    if (instr_req) begin
      check_val("instr_addr", instr_addr, exp_addr);
    end

    // Model advance for the coming clock edge.
    if (resp) r = mem_q.pop_front();
    if (cu_force) begin
      exp_q.delete();
      epoch++;
      exp_addr = cu_force_pc & ~32'd3;
    end else begin
      if (exp_valid && !cu_stall) void'(exp_q.pop_front());
      if (resp && (r.epoch == epoch)) exp_q.push_back({mem_word(r.addr), r.addr});
    end
    if (instr_req) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      nr.addr  = instr_addr;
      nr.due   = due;
      nr.epoch = epoch;
      mem_q.push_back(nr);
      if (!cu_force) exp_addr = exp_addr + 32'd4;
      check_val("inflight_bound", {31'b0, mem_q.size() <= MAXO}, 32'd1);
    end
  endtask

  task automatic run(input int n, input int lat_lo, input int lat_hi,
                     input int p_stall, input int p_kill, input int p_force);
    for (int i = 0; i < n; i++) step(lat_lo, lat_hi, p_stall, p_kill, p_force, 1'b0, '0);
  endtask

  task automatic force_to(input logic [XLEN-1:0] pc, input int lat);
    step(lat, lat, 0, 0, 100, 1'b1, pc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    arstn = 1'b0;
    do_reset(32'h0000_0100);

    // Streaming with a 1-cycle memory and no stalls.
    run(20, 1, 1, 0, 0, 0);

    // Decode stalled: buffer fills, requests stop, then drain in order.
    run(10, 1, 1, 100, 0, 0);
    check_val("full_req_low", {31'b0, instr_req}, 32'd0);
    run(10, 1, 1, 0, 0, 0);

    // Longer latency, outstanding limit exercised.
    run(40, 3, 3, 0, 0, 0);

    // Redirect with requests in flight.
    run(3, 3, 3, 0, 0, 0);
    force_to(32'h0000_0200, 3);
    check_val("force_fifo_empty", {31'b0, f_stall_req}, 32'd1);
    run(15, 3, 3, 0, 0, 0);

    // Kill alone for one cycle on a full FIFO.
    run(8, 1, 1, 100, 0, 0);
    run(1, 1, 1, 0, 100, 0);
    run(6, 1, 1, 0, 0, 0);

    // PC wrap across 2^32.
    force_to(32'hFFFF_FFF6, 1);
    run(15, 1, 2, 20, 0, 0);

    // Random mix including redirects racing responses and pops.
    run(400, 1, 4, 30, 10, 6);

    // Reset in the middle of traffic, unaligned boot address.
    run(5, 2, 3, 0, 0, 0);
    do_reset(32'h8000_0002);
    run(400, 1, 4, 25, 10, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
